// File: rtl/hub75_scan_reader.sv
// Read-side scanner for the frame buffer: fetches one row pair at a time,
// shifts it into a HUB75 panel, latches it and lights it for a fixed time.
module hub75_scan_reader #(
  parameter int unsigned PANEL_WIDTH    = 32,
  parameter int unsigned ROW_BITS       = 4,
  parameter int unsigned ADDR_WIDTH     = 9,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned DISPLAY_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  r_en,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic [2:0]            rgb1,
  output logic [2:0]            rgb2,
  output logic                  pix_clk,
  output logic                  lat,
  output logic                  oe_n,
  output logic [ROW_BITS-1:0]   row_addr,
  output logic                  frame_done
);

  localparam int unsigned COL_W = (PANEL_WIDTH > 1) ? $clog2(PANEL_WIDTH) : 1;
  localparam int unsigned CNT_W = $clog2(DISPLAY_CYCLES + 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(PANEL_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DISPLAY_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_CLK_HI,
    S_BLANK,
    S_LATCH,
    S_DISPLAY
  } state_e;

  state_e                state_q, state_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_BITS-1:0]   row_q, row_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
  logic                  r_en_q, r_en_d;
  logic [2:0]            rgb1_q, rgb1_d;
  logic [2:0]            rgb2_q, rgb2_d;
  logic                  pix_clk_q, pix_clk_d;
  logic                  lat_q, lat_d;
  logic                  oe_n_q, oe_n_d;
  logic [ROW_BITS-1:0]   row_addr_q, row_addr_d;
  logic                  frame_done_q, frame_done_d;

  // Only the low six data bits carry pixel colour.
  if (DATA_WIDTH > 6) begin : g_unused_data
    logic unused_data_hi;
    assign unused_data_hi = ^r_data[DATA_WIDTH-1:6];
  end

  // Next state, counters and the registered outputs of the state being entered.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    cnt_d        = cnt_q;
    r_addr_d     = r_addr_q;
    rgb1_d       = rgb1_q;
    rgb2_d       = rgb2_q;
    row_addr_d   = row_addr_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        rgb1_d  = r_data[2:0];
        rgb2_d  = r_data[5:3];
        state_d = S_CLK_HI;
      end
      S_CLK_HI: begin
        if (col_q == COL_LAST) begin
          col_d   = '0;
          state_d = S_BLANK;
        end else begin
          col_d   = col_q + COL_W'(1);
          state_d = S_FETCH;
        end
      end
      S_BLANK: begin
        state_d = S_LATCH;
      end
      S_LATCH: begin
        cnt_d   = CNT_LOAD;
        state_d = S_DISPLAY;
      end
      S_DISPLAY: begin
        if (cnt_q == '0) begin
          row_d        = row_q + ROW_BITS'(1);
          frame_done_d = (row_q == '1);
          state_d      = enable ? S_FETCH : S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    r_en_d    = (state_d == S_FETCH);
    pix_clk_d = (state_d == S_CLK_HI);
    lat_d     = (state_d == S_LATCH);
    oe_n_d    = (state_d != S_DISPLAY);
    if (state_d == S_FETCH) begin
      r_addr_d = ADDR_WIDTH'(row_d) * ADDR_WIDTH'(PANEL_WIDTH) + ADDR_WIDTH'(col_d);
    end
    if (state_d == S_LATCH) begin
      row_addr_d = row_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      cnt_q        <= '0;
      r_addr_q     <= '0;
      r_en_q       <= 1'b0;
      rgb1_q       <= '0;
      rgb2_q       <= '0;
      pix_clk_q    <= 1'b0;
      lat_q        <= 1'b0;
      oe_n_q       <= 1'b1;
      row_addr_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      cnt_q        <= cnt_d;
      r_addr_q     <= r_addr_d;
      r_en_q       <= r_en_d;
      rgb1_q       <= rgb1_d;
      rgb2_q       <= rgb2_d;
      pix_clk_q    <= pix_clk_d;
      lat_q        <= lat_d;
      oe_n_q       <= oe_n_d;
      row_addr_q   <= row_addr_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign r_addr     = r_addr_q;
  assign r_en       = r_en_q;
  assign rgb1       = rgb1_q;
  assign rgb2       = rgb2_q;
  assign pix_clk    = pix_clk_q;
  assign lat        = lat_q;
  assign oe_n       = oe_n_q;
  assign row_addr   = row_addr_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hub75_scan_reader.sv
// Bench for hub75_scan_reader: a row-phase timeline model checked every cycle,
// plus directed literal checks of row timing, pixel data, pause and reset.
module tb_hub75_scan_reader;

  localparam int W      = 32;
  localparam int ROWS   = 16;
  localparam int SHIFT  = 3 * W;
  localparam int PERIOD = SHIFT + 2 + 64;
  localparam int FRAME  = PERIOD * ROWS;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [8:0]  r_addr;
  logic        r_en;
  logic [15:0] r_data;
  logic [2:0]  rgb1, rgb2;
  logic        pix_clk, lat, oe_n;
  logic [3:0]  row_addr;
  logic        frame_done;

  logic [15:0] mem [512];
  int checks = 0;
  int errors = 0;

  hub75_scan_reader dut (
    .clk(clk), .rst(rst), .enable(enable),
    .r_addr(r_addr), .r_en(r_en), .r_data(r_data),
    .rgb1(rgb1), .rgb2(rgb2), .pix_clk(pix_clk), .lat(lat), .oe_n(oe_n),
    .row_addr(row_addr), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Synchronous frame-buffer read port.
  always @(posedge clk) if (r_en) r_data <= mem[r_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ren(input int budget, input string name);
    int n = 0;
    while (!r_en && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_timeout"}, 32'(r_en), 32'd1);
  endtask

  // Timeline model: a running scan is a phase 0..PERIOD-1 inside the current row.
  int          m_act, m_ph, m_row, m_addr, m_rowaddr, m_fd;
  logic [2:0]  m_rgb1, m_rgb2;

  initial begin
    m_act = 0; m_ph = 0; m_row = 0; m_addr = 0; m_rowaddr = 0; m_fd = 0;
    m_rgb1 = '0; m_rgb2 = '0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_act = 0; m_ph = 0; m_row = 0; m_addr = 0; m_rowaddr = 0; m_fd = 0;
        m_rgb1 = '0; m_rgb2 = '0;
      end else begin
        m_fd = 0;
        if (m_act != 0 && m_ph < SHIFT && m_ph % 3 == 1) begin
          m_rgb1 = mem[m_addr][2:0];
          m_rgb2 = mem[m_addr][5:3];
        end
        if (m_act == 0) begin
          if (enable) begin
            m_act = 1;
            m_ph  = 0;
          end
        end else if (m_ph == PERIOD - 1) begin
          m_fd  = (m_row == ROWS - 1) ? 1 : 0;
          m_row = (m_row + 1) % ROWS;
          m_act = enable ? 1 : 0;
          m_ph  = 0;
        end else begin
          m_ph++;
        end
        if (m_act != 0 && m_ph < SHIFT && m_ph % 3 == 0) m_addr = m_row * W + m_ph / 3;
        if (m_act != 0 && m_ph == SHIFT + 1) m_rowaddr = m_row;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic e_ren, e_pix, e_lat, e_oen;
    e_ren = (m_act != 0) && m_ph < SHIFT && (m_ph % 3 == 0);
    e_pix = (m_act != 0) && m_ph < SHIFT && (m_ph % 3 == 2);
    e_lat = (m_act != 0) && m_ph == SHIFT + 1;
    e_oen = !((m_act != 0) && m_ph >= SHIFT + 2);
    chk("cycle",
        {8'd0, r_en, r_addr, pix_clk, lat, oe_n, row_addr, frame_done, rgb1, rgb2},
        {8'd0, e_ren, 9'(m_addr), e_pix, e_lat, e_oen, 4'(m_rowaddr), m_fd[0], m_rgb1, m_rgb2});
  end

  initial begin
    int ren_cnt, n, bad_fetch, lat_n, lat_bad, fd_n, oe_low, idle_bad;
    rst = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 512; i++) mem[i] = 16'($urandom);
    mem[5] = 16'h002B;
    mem[6] = 16'hFFC0;
    #1 rst = 1'b1;
    repeat (3) tick();
    chk("reset_vals", {r_en, r_addr, pix_clk, lat, oe_n, row_addr, frame_done, rgb1, rgb2},
        {1'b0, 9'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 3'd0, 3'd0});
    rst = 1'b0;

    // Idle with enable low: no fetches.
    ren_cnt = 0;
    repeat (100) begin
      tick();
      if (r_en) ren_cnt++;
    end
    chk("idle_no_ren", ren_cnt, 0);
    chk("idle_oe_n", 32'(oe_n), 1);

    // One full frame from a standing start.
    enable = 1'b1;
    wait_ren(5, "start");
    bad_fetch = 0; lat_n = 0; lat_bad = 0; fd_n = 0; oe_low = 0;
    for (int k = 0; k <= FRAME; k++) begin
      if (k < SHIFT) begin
        if (r_en !== (k % 3 == 0)) bad_fetch++;
        if (k % 3 == 0 && r_addr !== 9'(k / 3)) bad_fetch++;
        if (pix_clk !== (k % 3 == 2)) bad_fetch++;
        if (k == 17) begin
          chk("rgb1_col5", 32'(rgb1), 32'b011);
          chk("rgb2_col5", 32'(rgb2), 32'b101);
        end
        if (k == 20) chk("rgb_col6_zero", {rgb1, rgb2}, 0);
      end
      if (k == 96) chk("blank", {oe_n, lat, pix_clk}, 3'b100);
      if (k == 97) chk("latch_row0", {lat, oe_n, row_addr}, {1'b1, 1'b1, 4'd0});
      if (k == 162) chk("row1_first_addr", {r_en, r_addr}, {1'b1, 9'd32});
      if (lat) begin
        lat_n++;
        if ((k - 97) % 162 != 0 || row_addr !== 4'((k - 97) / 162)) lat_bad++;
      end
      if (!oe_n) oe_low++;
      if (frame_done) begin
        fd_n++;
        chk("frame_done_cycle", k, 2592);
      end
      if (k < FRAME) tick();
    end
    chk("row0_fetch_pattern", bad_fetch, 0);
    chk("lat_count", lat_n, 16);
    chk("lat_spacing", lat_bad, 0);
    chk("frame_done_count", fd_n, 1);
    chk("oe_low_total", oe_low, 1024);
    chk("frame2_row0_addr", {r_en, r_addr}, {1'b1, 9'd0});

    // Drop enable while row 3 is shifting.
    repeat (516) tick();
    enable = 1'b0;
    n = 0;
    while (!lat && n < 200) begin
      tick();
      n++;
    end
    chk("pause_lat_row", {lat, row_addr}, {1'b1, 4'd3});
    tick();
    n = 0;
    while (!oe_n && n < 100) begin
      n++;
      tick();
    end
    chk("pause_display_len", n, 64);
    idle_bad = 0;
    repeat (50) begin
      if (r_en || !oe_n) idle_bad++;
      tick();
    end
    chk("pause_idle", idle_bad, 0);
    enable = 1'b1;
    wait_ren(5, "resume");
    chk("resume_addr", 32'(r_addr), 128);

    // Async reset during CLK_HI of row 2, column 10.
    n = 0;
    while (!(r_en && r_addr == 9'd74) && n < 6000) begin
      tick();
      n++;
    end
    chk("find_col10_row2", {r_en, r_addr}, {1'b1, 9'd74});
    tick();
    tick();
    chk("clk_hi_before_rst", 32'(pix_clk), 1);
    rst = 1'b1;
    #1;
    chk("async_reset", {pix_clk, oe_n, lat, r_en, frame_done, rgb1, rgb2, row_addr, r_addr},
        {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 4'd0, 9'd0});
    tick();
    tick();
    rst = 1'b0;
    wait_ren(5, "after_reset");
    chk("after_reset_addr", 32'(r_addr), 0);

    // Random enable toggles and occasional resets against the model.
    repeat (4000) begin
      tick();
      if ($urandom_range(0, 149) == 0) enable = ~enable;
      if ($urandom_range(0, 1999) == 0) begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
